// File: rtl/br_pkg.sv
// Shared constants and types for the register-bank write path.
package br_pkg;

    localparam int ANCHO = 32;
    localparam int DIR   = 5;
    localparam int N_REG = 32;

    typedef enum logic {INIT, RUN} estado_t;

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_t;

endpackage

// File: rtl/rr_arbitro_2.sv
// Two-way round-robin arbiter: one-hot grant, pointer flips away from the winner.
module rr_arbitro_2
    import br_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt,
    output req_t       prio
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio == REQ_A) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Idle cycles leave the pointer untouched.
    always_ff @(posedge clk) begin
        if (rst)
            prio <= REQ_A;
        else if (adv && (gnt != 2'b00))
            prio <= gnt[0] ? REQ_B : REQ_A;
    end

endmodule

// File: rtl/br_arbitro_escritura.sv
// Write-port controller: zero-fills the bank after reset, then arbitrates
// the single write port between ALU (A) and load (B) writebacks.
module br_arbitro_escritura #(
    parameter int N_REG = br_pkg::N_REG,
    parameter int DIR   = br_pkg::DIR,
    parameter int ANCHO = br_pkg::ANCHO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [DIR-1:0]   a_dir,
    input  logic [ANCHO-1:0] a_dato,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [DIR-1:0]   b_dir,
    input  logic [ANCHO-1:0] b_dato,
    output logic             WE,
    output logic [DIR-1:0]   DE,
    output logic [ANCHO-1:0] Dato,
    output logic             listo
);
    import br_pkg::*;

    localparam logic [DIR-1:0] ULTIMO = DIR'(N_REG - 1);

    estado_t          estado;
    logic [DIR-1:0]   cnt;
    logic [1:0]       gnt;
    req_t             prio;
    logic             run;
    logic             xfer;
    logic [DIR-1:0]   sel_dir;
    logic [ANCHO-1:0] sel_dato;

    assign run = (estado == RUN);

    rr_arbitro_2 u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  ({b_valid, a_valid}),
        .adv  (run),
        .gnt  (gnt),
        .prio (prio)
    );

    assign a_ready = run && gnt[0];
    assign b_ready = run && gnt[1];
    assign xfer    = a_ready || b_ready;

    assign sel_dir  = gnt[1] ? b_dir  : a_dir;
    assign sel_dato = gnt[1] ? b_dato : a_dato;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= INIT;
            cnt    <= '0;
            WE     <= 1'b0;
            DE     <= '0;
            Dato   <= '0;
            listo  <= 1'b0;
        end else begin
            case (estado)
                INIT: begin
                    WE   <= 1'b1;
                    DE   <= cnt;
                    Dato <= '0;
                    cnt  <= cnt + 1'b1;
                    if (cnt == ULTIMO) begin
                        estado <= RUN;
                        listo  <= 1'b1;
                    end
                end
                RUN: begin
                    // Writes to register 0 complete the handshake but never reach the bank.
                    if (xfer && (sel_dir != '0)) begin
                        WE   <= 1'b1;
                        DE   <= sel_dir;
                        Dato <= sel_dato;
                    end else begin
                        WE <= 1'b0;
                    end
                end
                default: estado <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_br_arbitro_escritura.sv
// Directed bench for br_arbitro_escritura: sweep, handshakes, round-robin, reg 0, mid-run reset.
module tb_br_arbitro_escritura;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_dir, b_dir;
    logic [31:0] a_dato, b_dato;
    logic        WE;
    logic [4:0]  DE;
    logic [31:0] Dato;
    logic        listo;

    int errors = 0;
    int checks = 0;

    logic [31:0] bank [0:31];

    always #5 clk = ~clk;

    br_arbitro_escritura dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_dir(a_dir), .a_dato(a_dato),
        .b_valid(b_valid), .b_ready(b_ready), .b_dir(b_dir), .b_dato(b_dato),
        .WE(WE), .DE(DE), .Dato(Dato), .listo(listo)
    );

    // Shadow of the register bank, fed from the write port.
    always @(posedge clk) if (WE === 1'b1) bank[DE] <= Dato;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_dir = '0; b_dir = '0; a_dato = '0; b_dato = '0;
        tick();
        checks++;
        if ({WE, DE, Dato, listo, a_ready, b_ready} !== '0) begin
            errors++;
            $display("FAIL reset: WE=%b DE=%0d Dato=%h listo=%b rdy=%b%b, required all zero",
                     WE, DE, Dato, listo, a_ready, b_ready);
        end
    endtask

    // Valids held high through most of the sweep: readies must stay low.
    task automatic run_sweep(input string tag);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < 30) begin a_valid = 1'b1; b_valid = 1'b1; end
            else begin a_valid = 1'b0; b_valid = 1'b0; end
            tick();
            checks++;
            if (WE !== 1'b1 || DE !== 5'(i) || Dato !== 32'h0 || a_ready !== 1'b0 || b_ready !== 1'b0
                || listo !== (i == 31)) begin
                errors++;
                $display("FAIL %s[%0d]: WE=%b DE=%0d Dato=%h rdy=%b%b listo=%b, required WE=1 DE=%0d Dato=0 rdy=00 listo=%b",
                         tag, i, WE, DE, Dato, a_ready, b_ready, listo, i, (i == 31));
            end
        end
    endtask

    task automatic test_init_sweep;
        run_sweep("sweep");
        tick();
        checks++;
        if (WE !== 1'b0 || listo !== 1'b1) begin
            errors++;
            $display("FAIL sweep_end: WE=%b listo=%b, required WE=0 listo=1", WE, listo);
        end
    endtask

    task automatic test_contention;
        a_valid = 1'b1; a_dir = 5'd1; a_dato = 32'h11;
        b_valid = 1'b1; b_dir = 5'd2; b_dato = 32'h22;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL cont_grant_a: rdy=%b%b, required 10", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        #1;
        checks++;
        if (WE !== 1'b1 || DE !== 5'd1 || Dato !== 32'h11 || {a_ready, b_ready} !== 2'b01) begin
            errors++;
            $display("FAIL cont_write_a: WE=%b DE=%0d Dato=%h rdy=%b%b, required 1/1/11/01", WE, DE, Dato, a_ready, b_ready);
        end
        tick();
        b_valid = 1'b0;
        checks++;
        if (WE !== 1'b1 || DE !== 5'd2 || Dato !== 32'h22) begin
            errors++; $display("FAIL cont_write_b: WE=%b DE=%0d Dato=%h, required 1/2/22", WE, DE, Dato);
        end
        tick();
        checks++;
        if (WE !== 1'b0) begin
            errors++; $display("FAIL cont_idle: WE=%b, required 0", WE);
        end
    endtask

    task automatic test_rotation;
        b_valid = 1'b1; b_dir = 5'd3; b_dato = 32'h33;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            errors++; $display("FAIL rot_b_alone: rdy=%b%b, required 01", a_ready, b_ready);
        end
        tick();
        b_valid = 1'b0;
        checks++;
        if (WE !== 1'b1 || DE !== 5'd3 || Dato !== 32'h33) begin
            errors++; $display("FAIL rot_write_b: WE=%b DE=%0d Dato=%h, required 1/3/33", WE, DE, Dato);
        end
        a_valid = 1'b1; a_dir = 5'd4; a_dato = 32'h44;
        b_valid = 1'b1; b_dir = 5'd6; b_dato = 32'h66;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL rot_grant_a: rdy=%b%b, required 10", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        #1;
        checks++;
        if (DE !== 5'd4 || Dato !== 32'h44 || b_ready !== 1'b1) begin
            errors++; $display("FAIL rot_then_b: DE=%0d Dato=%h b_ready=%b, required 4/44/1", DE, Dato, b_ready);
        end
        tick();
        b_valid = 1'b0;
        checks++;
        if (WE !== 1'b1 || DE !== 5'd6 || Dato !== 32'h66) begin
            errors++; $display("FAIL rot_write_b2: WE=%b DE=%0d Dato=%h, required 1/6/66", WE, DE, Dato);
        end
    endtask

    task automatic test_single_write;
        a_valid = 1'b1; a_dir = 5'd5; a_dato = 32'hDEADBEEF;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready: rdy=%b%b, required 10", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (WE !== 1'b1 || DE !== 5'd5 || Dato !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write: WE=%b DE=%0d Dato=%h, required 1/5/deadbeef", WE, DE, Dato);
        end
        tick();
        checks++;
        if (WE !== 1'b0) begin
            errors++; $display("FAIL single_idle: WE=%b, required 0", WE);
        end
    endtask

    task automatic test_reg0;
        b_valid = 1'b1; b_dir = 5'd0; b_dato = 32'hFFFFFFFF;
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            errors++; $display("FAIL reg0_ready: b_ready=%b, required 1", b_ready);
        end
        tick();
        b_valid = 1'b0;
        checks++;
        if (WE !== 1'b0) begin
            errors++; $display("FAIL reg0_we: WE=%b, required 0", WE);
        end
        tick();
        checks++;
        if (bank[0] !== 32'h0 || bank[5] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reg0_bank: bank0=%h bank5=%h, required 0/deadbeef", bank[0], bank[5]);
        end
        // prio now back on A: B was granted last.
        a_valid = 1'b1; a_dir = 5'd7; a_dato = 32'h77;
        b_valid = 1'b1; b_dir = 5'd8; b_dato = 32'h88;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL reg0_prio: rdy=%b%b, required 10", a_ready, b_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        // Valids still high from the previous task: A then B then A.
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10) || WE !== 1'b1) begin
                errors++; $display("FAIL alt[%0d]: rdy=%b%b WE=%b, required %b WE=1",
                                   i, a_ready, b_ready, WE, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0 || WE !== 1'b0 || listo !== 1'b0) begin
            errors++; $display("FAIL midrst: rdy=%b%b WE=%b listo=%b, required 00/0/0", a_ready, b_ready, WE, listo);
        end
        run_sweep("resweep");
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL post_rst_prio: rdy=%b%b, required 10", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if (WE !== 1'b1 || DE !== 5'd7 || Dato !== 32'h77) begin
            errors++; $display("FAIL post_rst_write: WE=%b DE=%0d Dato=%h, required 1/7/77", WE, DE, Dato);
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_contention();
        test_rotation();
        test_single_write();
        test_reg0();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
